// File: rtl/xor_checksum16_pkg.sv
// Shared definitions for the xor_checksum16 block.
//   WORD_W  : datapath word width
//   state_t : checksum FSM states (encodings kept from the original design)
package xor_checksum16_pkg;

  localparam int unsigned WORD_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/xor_checksum16_xor16.sv
// xor16: bitwise XOR of two 16-bit words, the fold stage of the checksum.
//   a : running accumulator
//   b : incoming word
//   y : a ^ b
module xor16
  import xor_checksum16_pkg::*;
(
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  output logic [WORD_W-1:0] y
);

  assign y = a ^ b;

endmodule

// File: rtl/xor_checksum16.sv
// xor_checksum16: streaming 16-bit XOR checksum over framed words.
//   clk, rst          : clock, synchronous active-high reset
//   in_valid/in_ready : input handshake; in_data word, in_first/in_last framing
//   out_valid/out_ready : result handshake
//   out_sum           : XOR of all words in the frame
//   out_count         : words in frame, saturating at MAX_WORDS
//   out_overflow      : frame exceeded MAX_WORDS words
//   err_orphan        : one-cycle pulse when a beat arrives outside a frame
module xor_checksum16
  import xor_checksum16_pkg::*;
#(
  parameter int unsigned CNT_W     = 5,
  parameter int unsigned MAX_WORDS = 31
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_first,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_sum,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_overflow,
  output logic              err_orphan
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WORDS);
  localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

  state_t            state, state_nx;
  logic [WORD_W-1:0] acc, acc_nx, fold;
  logic [CNT_W-1:0]  count, count_nx;
  logic              overflow, overflow_nx;
  logic              orphan_nx;
  logic              load_out;
  logic              accept;

  assign in_ready  = (state == ST_IDLE) || (state == ST_ACCUM);
  assign out_valid = (state == ST_DONE);
  assign accept    = in_valid && in_ready;

  xor16 u_xor16 (
    .a (acc),
    .b (in_data),
    .y (fold)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // Result registers are loaded from the next-state values on the same edge
  // that enters DONE, so out_valid and the result appear together.
  always_comb begin
    state_nx    = state;
    acc_nx      = acc;
    count_nx    = count;
    overflow_nx = overflow;
    orphan_nx   = 1'b0;
    load_out    = 1'b0;
    case (state)
      ST_IDLE, ST_ACCUM: begin
        if (accept) begin
          if (in_first) begin
            // Frame start; in ACCUM this silently drops the partial frame.
            acc_nx      = in_data;
            count_nx    = ONE_CNT;
            overflow_nx = 1'b0;
            state_nx    = ST_ACCUM;
            if (in_last) begin
              state_nx = ST_DONE;
              load_out = 1'b1;
            end
          end else if (state == ST_ACCUM) begin
            acc_nx = fold;
            if (count == MAX_CNT) overflow_nx = 1'b1;
            else                  count_nx    = count + ONE_CNT;
            if (in_last) begin
              state_nx = ST_DONE;
              load_out = 1'b1;
            end
          end else begin
            orphan_nx = 1'b1;
          end
        end
      end
      ST_DONE: begin
        if (out_ready) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc          <= '0;
      count        <= '0;
      overflow     <= 1'b0;
      out_sum      <= '0;
      out_count    <= '0;
      out_overflow <= 1'b0;
      err_orphan   <= 1'b0;
    end else begin
      acc        <= acc_nx;
      count      <= count_nx;
      overflow   <= overflow_nx;
      err_orphan <= orphan_nx;
      if (load_out) begin
        out_sum      <= acc_nx;
        out_count    <= count_nx;
        out_overflow <= overflow_nx;
      end
    end
  end

endmodule
